log_reader: RTL and testbench

LOG_READER -- requirements
Module: log_reader

---
 rtl/dsp_pkg.sv | 17 +
 rtl/skid_fifo.sv | 56 +++++
 rtl/log_reader.sv | 131 +++++++++++++
 tb/tb_log_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types and constants for the capture-memory log reader.
package dsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Buffered words plus reads still in flight may never exceed the FIFO depth.
  localparam logic [2:0] CREDIT_LIMIT = 3'd2;

  function automatic logic [63:0] header_word(input int unsigned addr_nbit);
    return 64'(1) << addr_nbit;
  endfunction

endpackage

// File: rtl/skid_fifo.sv
// Two-entry FIFO that decouples the fixed-latency RAM read path from the consumer.
module skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = i_pop && (count_q != 2'd0);
  assign do_push = i_push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_data;
    end
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = (count_q == 2'd2);
  assign o_empty = (count_q == 2'd0);
  assign o_count = count_q;

endmodule

// File: rtl/log_reader.sv
// Streams captured RAM contents over a valid/ready port in ascending address order.
// Define LOG_READER_HEADER_EN to prepend one word holding the RAM depth before sample 0.
module log_reader
  import dsp_pkg::*;
#(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_NBIT = 15
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_mem_done,
  output logic                     o_ram_read,
  output logic [RAM_ADDR_NBIT-1:0] o_ram_addr,
  input  logic [RAM_WIDTH-1:0]     i_ram_data,
  output logic [RAM_WIDTH-1:0]     o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam logic [RAM_ADDR_NBIT-1:0] LAST_ADDR = '1;

  state_t                   state_q, state_d;
  logic [RAM_ADDR_NBIT-1:0] cnt_q, cnt_d;
  logic [RAM_ADDR_NBIT-1:0] addr_q, addr_d;
  logic                     inflight_q, inflight_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [1:0]               fifo_count;
  logic [RAM_WIDTH-1:0]     fifo_wdata;
  logic [2:0]               credit;
  logic                     start_ok, issue, drain_done, push_ok;

  assign start_ok = (state_q == ST_IDLE) && i_start && i_mem_done;
  assign fifo_pop = !fifo_empty && i_ready;
  assign push_ok  = !fifo_full || fifo_pop;

  // Occupancy after this cycle's pop, plus the read whose data lands this cycle.
  assign credit     = {1'b0, fifo_count} - {2'b0, fifo_pop} + {2'b0, inflight_q};
  assign issue      = (state_q == ST_READ) && (credit < CREDIT_LIMIT);
  assign drain_done = (state_q == ST_DRAIN) && (credit == 3'd0);

`ifdef LOG_READER_HEADER_EN
  localparam logic [RAM_WIDTH-1:0] HEADER = RAM_WIDTH'(header_word(RAM_ADDR_NBIT));

  // The FIFO is empty and nothing is in flight in IDLE, so the header slots in first.
  assign fifo_push  = (inflight_q || start_ok) && push_ok;
  assign fifo_wdata = start_ok ? HEADER : i_ram_data;
`else
  assign fifo_push  = inflight_q && push_ok;
  assign fifo_wdata = i_ram_data;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    inflight_d = issue;
    addr_d     = issue ? cnt_q : addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_READ;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (issue) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + RAM_ADDR_NBIT'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  skid_fifo #(
    .WIDTH(RAM_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_push (fifo_push),
    .i_data (fifo_wdata),
    .i_pop  (fifo_pop),
    .o_data (o_data),
    .o_full (fifo_full),
    .o_empty(fifo_empty),
    .o_count(fifo_count)
  );

  assign o_ram_read = issue;
  assign o_ram_addr = issue ? cnt_q : addr_q;
  assign o_valid    = !fifo_empty;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_log_reader.sv
// Scoreboard bench for log_reader with a 16-entry capture RAM (mem[k] = k + 0x100).
// Honours LOG_READER_HEADER_EN by expecting the depth word ahead of the samples.
module tb_log_reader;

`ifdef LOG_READER_HEADER_EN
  localparam int S0 = 1;
`else
  localparam int S0 = 0;
`endif
  localparam int NWORDS = 16 + S0;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_mem_done, i_ready;
  logic        o_ram_read, o_valid, o_busy, o_done;
  logic [3:0]  o_ram_addr;
  logic [31:0] ramData, o_data;

  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] expQ[$];
  int          readCount = 0, wordIdx = 0, doneCount = 0, cycleCount = 0;
  int          busyRise = 0, doneCycle = 0, readyMode = 0, phase = 0;
  int          acceptCycle[64];
  logic        busyEver = 1'b0, prevStall = 1'b0, prevBusy = 1'b0;
  logic [31:0] prevData = '0;

  always #5 clk = ~clk;

  log_reader #(
    .RAM_WIDTH    (32),
    .RAM_ADDR_NBIT(4)
  ) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_mem_done(i_mem_done),
    .o_ram_read(o_ram_read),
    .o_ram_addr(o_ram_addr),
    .i_ram_data(ramData),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  // Capture RAM with one cycle of read latency; junk when no read was issued.
  always @(posedge clk) begin
    if (o_ram_read) ramData <= 32'h100 + {28'b0, o_ram_addr};
    else            ramData <= 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Consumer ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = never ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (readyMode)
        0:       i_ready = 1'b1;
        1:       i_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, consumes the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      cycleCount++;
      if (o_ram_read) begin
        checkOutput("ramAddr", {28'b0, o_ram_addr}, 32'(readCount));
        readCount++;
      end
      if (o_busy && !prevBusy) busyRise = cycleCount;
      if (o_busy) busyEver = 1'b1;
      if (o_done) begin
        doneCount++;
        doneCycle = cycleCount;
        checkOutput("busyAtDone", 32'(o_busy), 32'd0);
      end
      if (prevStall && !i_rst) begin
        checkOutput("stallValid", 32'(o_valid), 32'd1);
        checkOutput("stallData", o_data, prevData);
      end
      if (o_valid && i_ready && !i_rst) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL extraWord: got 0x%08h, expected no word", o_data);
        end else begin
          checkOutput("word", o_data, expQ.pop_front());
        end
        if (wordIdx < 64) acceptCycle[wordIdx] = cycleCount;
        wordIdx++;
      end
      prevStall = o_valid && !i_ready && !i_rst;
      prevData  = o_data;
      prevBusy  = o_busy;
    end
  end

  task automatic applyStimulus(input int mode);
    readyMode = mode;
    phase     = 0;
    i_ready   = (mode != 2);
    expQ.delete();
`ifdef LOG_READER_HEADER_EN
    expQ.push_back(32'h0000_0010);
`endif
    for (int k = 0; k < 16; k++) expQ.push_back(32'h100 + 32'(k));
    readCount  = 0;
    wordIdx    = 0;
    busyEver   = 1'b0;
    i_mem_done = 1'b1;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (doneCount < target && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("doneSeen", 32'(doneCount >= target), 32'd1);
  endtask

  task automatic checkIdleZero(input string tag);
    $display("[TB] idle check: %s", tag);
    checkOutput("rstValid", 32'(o_valid), 32'd0);
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    checkOutput("rstDone", 32'(o_done), 32'd0);
    checkOutput("rstRead", 32'(o_ram_read), 32'd0);
    checkOutput("rstData", o_data, 32'd0);
    checkOutput("rstAddr", {28'b0, o_ram_addr}, 32'd0);
  endtask

  initial begin
    int doneSnap;
    int n;
    i_rst = 1'b1; i_start = 1'b0; i_mem_done = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkIdleZero("power-on reset");
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] dump with consumer always ready");
    applyStimulus(0);
    waitDone(1);
    checkOutput("reads", 32'(readCount), 32'd16);
    checkOutput("words", 32'(wordIdx), 32'(NWORDS));
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("firstLatency", 32'(acceptCycle[S0] - busyRise), 32'd2);
    checkOutput("burstSpan", 32'(acceptCycle[S0 + 15] - acceptCycle[S0]), 32'd15);
    checkOutput("doneAfterLast", 32'(doneCycle - acceptCycle[NWORDS - 1]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("donePulses", 32'(doneCount), 32'd1);

    $display("[TB] dump with ready pattern 1,0,0,1");
    applyStimulus(1);
    waitDone(2);
    checkOutput("readsStall", 32'(readCount), 32'd16);
    checkOutput("wordsStall", 32'(wordIdx), 32'(NWORDS));
    checkOutput("queueEmptyStall", 32'(expQ.size()), 32'd0);

    $display("[TB] start without capture done, then start while busy");
    readyMode = 0;
    busyEver = 1'b0; readCount = 0;
    i_mem_done = 1'b0; i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("ignoredBusy", 32'(busyEver), 32'd0);
    checkOutput("ignoredReads", 32'(readCount), 32'd0);
    applyStimulus(0);
    repeat (4) @(posedge clk);
    #1;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    waitDone(3);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("busyStartReads", 32'(readCount), 32'd16);
    checkOutput("busyStartWords", 32'(wordIdx), 32'(NWORDS));
    checkOutput("busyStartDone", 32'(doneCount), 32'd3);
    checkOutput("busyStartIdle", 32'(o_busy), 32'd0);

    $display("[TB] reset after five accepted words");
    applyStimulus(0);
    n = 0;
    while (wordIdx < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reachedFive", 32'(wordIdx >= 5), 32'd1);
    doneSnap = doneCount;
    i_rst = 1'b1; readyMode = 2; i_ready = 1'b0;
    @(posedge clk);
    #1;
    checkIdleZero("mid-dump reset");
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    expQ.delete();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("noDoneOnAbort", 32'(doneCount), 32'(doneSnap));
    applyStimulus(0);
    waitDone(doneSnap + 1);
    checkOutput("restartReads", 32'(readCount), 32'd16);
    checkOutput("restartWords", 32'(wordIdx), 32'(NWORDS));
    checkOutput("restartQueue", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
